// File: rtl/firebird_ifu.sv
// firebird_ifu: instruction fetch unit. Holds the PC, keeps a single
// instruction-memory request in flight and hands the returned word to
// decode under a valid/ready handshake. Execute may redirect the PC at any
// time; a fetch already in flight is then killed.
module firebird_ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  inst_opcode,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        misalign_q, misalign_d;

  // Next-state logic: normal fetch sequencing, then redirect overrides the PC.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    misalign_d   = misalign_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          // A redirect in the accept cycle orphans the request just issued.
          kill_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (!kill_q && !redirect_valid) begin
            inst_d       = imem_rsp_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = S_HOLD;
          end else begin
            state_d = S_FETCH;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          inst_valid_d = 1'b0;
          state_d      = S_FETCH;
        end else if (inst_ready) begin
          pc_d         = pc_q + 32'd4;
          inst_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Redirect takes precedence over pc+4; the PC is always kept word aligned.
    if (redirect_valid && (state_q != S_IDLE)) begin
      pc_d = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_req_valid = (state_q == S_FETCH);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_opcode    = inst_q[6:0];
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_firebird_ifu.sv
// Self-checking bench for firebird_ifu: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_firebird_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  inst_opcode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  int vec = 0;
  int err = 0;
  int cycle = 0;

  firebird_ifu #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_opcode    (inst_opcode),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  // Free-running cycle count used to measure issue spacing.
  always @(posedge clk) cycle <= cycle + 1;

  // Hard stop if something hangs.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  // Leaves the DUT one negedge after reset release plus one cycle (issuing).
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  // Memory driver: accept one request, answer lat cycles later.
  task automatic serve(input logic [31:0] data, input int lat,
                       output logic [31:0] addr, output int waited);
    waited = 0;
    imem_req_ready = 1'b1;
    while (!imem_req_valid && waited < 20) begin cyc(); waited++; end
    addr = imem_req_addr;
    cyc();
    imem_req_ready = 1'b0;
    for (int i = 1; i < lat; i++) cyc();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    cyc();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    cyc(); cyc(); cyc();
    vec++; if (imem_req_valid !== 1'b0) begin err++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
    vec++; if (inst_valid !== 1'b0) begin err++; $display("FAIL rst_inst_valid got %b exp 0", inst_valid); end
    vec++; if (inst !== 32'h0) begin err++; $display("FAIL rst_inst got %h exp 0", inst); end
    vec++; if (inst_pc !== 32'h0) begin err++; $display("FAIL rst_inst_pc got %h exp 0", inst_pc); end
    vec++; if (inst_opcode !== 7'h0) begin err++; $display("FAIL rst_opcode got %h exp 0", inst_opcode); end
    vec++; if (misalign_err !== 1'b0) begin err++; $display("FAIL rst_misalign got %b exp 0", misalign_err); end
    rst = 1'b0;
    vec++; if (imem_req_valid !== 1'b0) begin err++; $display("FAIL idle_req_valid got %b exp 0", imem_req_valid); end
    cyc();
    vec++; if (imem_req_valid !== 1'b1) begin err++; $display("FAIL first_req_valid got %b exp 1", imem_req_valid); end
    vec++; if (imem_req_addr !== 32'h100) begin err++; $display("FAIL first_req_addr got %h exp 00000100", imem_req_addr); end
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    vec++; if (imem_req_valid !== 1'b0) begin err++; $display("FAIL wait_req_valid got %b exp 0", imem_req_valid); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    cyc();
    imem_rsp_valid = 1'b0;
    vec++; if (inst_valid !== 1'b1) begin err++; $display("FAIL first_inst_valid got %b exp 1", inst_valid); end
    vec++; if (inst_pc !== 32'h100) begin err++; $display("FAIL first_inst_pc got %h exp 00000100", inst_pc); end
    vec++; if (inst !== 32'h13) begin err++; $display("FAIL first_inst got %h exp 00000013", inst); end
    vec++; if (inst_opcode !== 7'h13) begin err++; $display("FAIL first_opcode got %h exp 13", inst_opcode); end
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    vec++; if (inst_valid !== 1'b0) begin err++; $display("FAIL consumed_inst_valid got %b exp 0", inst_valid); end
    vec++; if (imem_req_addr !== 32'h104) begin err++; $display("FAIL next_req_addr got %h exp 00000104", imem_req_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] words [3];
    logic [31:0] a;
    int wt, t, tprev;
    words[0] = 32'h0000_0033; words[1] = 32'h0000_0063; words[2] = 32'h0000_0003;
    tprev = 0;
    do_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      serve(words[i], 1, a, wt);
      t = cycle;
      vec++; if (wt >= 20) begin err++; $display("FAIL stream_timeout got %0d exp <20", wt); end
      vec++; if (a !== 32'h100 + 4 * i) begin err++; $display("FAIL stream_req_addr got %h exp %h", a, 32'h100 + 4 * i); end
      vec++; if (inst_valid !== 1'b1) begin err++; $display("FAIL stream_valid got %b exp 1", inst_valid); end
      vec++; if (inst_pc !== 32'h100 + 4 * i) begin err++; $display("FAIL stream_pc got %h exp %h", inst_pc, 32'h100 + 4 * i); end
      vec++; if (inst_opcode !== words[i][6:0]) begin err++; $display("FAIL stream_opcode got %h exp %h", inst_opcode, words[i][6:0]); end
      if (i > 0) begin
        vec++; if (t - tprev !== 3) begin err++; $display("FAIL stream_spacing got %0d exp 3", t - tprev); end
      end
      tprev = t;
      inst_ready = 1'b1;
      cyc();
      inst_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, si, sp;
    int wt;
    serve(32'h0000_0023, 2, a, wt);
    si = inst; sp = inst_pc;
    vec++; if (sp !== 32'h10C) begin err++; $display("FAIL bp_pc got %h exp 0000010c", sp); end
    for (int unsigned i = 0; i < 5; i++) begin
      cyc();
      vec++; if (inst_valid !== 1'b1) begin err++; $display("FAIL bp_valid got %b exp 1", inst_valid); end
      vec++; if (inst !== 32'h23) begin err++; $display("FAIL bp_inst got %h exp 00000023", inst); end
      vec++; if (inst_pc !== sp) begin err++; $display("FAIL bp_inst_pc got %h exp %h", inst_pc, sp); end
      vec++; if (imem_req_valid !== 1'b0) begin err++; $display("FAIL bp_req_valid got %b exp 0", imem_req_valid); end
    end
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    vec++; if (inst_valid !== 1'b0) begin err++; $display("FAIL bp_release_valid got %b exp 0", inst_valid); end
    vec++; if (imem_req_addr !== sp + 32'd4) begin err++; $display("FAIL bp_next_addr got %h exp %h", imem_req_addr, sp + 32'd4); end
  endtask

  task automatic test_kill();
    logic [31:0] a;
    int wt;
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc();
    redirect_valid = 1'b0;
    vec++; if (imem_req_valid !== 1'b0) begin err++; $display("FAIL kill_wait_req got %b exp 0", imem_req_valid); end
    cyc();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    cyc();
    imem_rsp_valid = 1'b0;
    vec++; if (inst_valid !== 1'b0) begin err++; $display("FAIL kill_dropped got %b exp 0", inst_valid); end
    vec++; if (imem_req_addr !== 32'h200) begin err++; $display("FAIL kill_next_addr got %h exp 00000200", imem_req_addr); end
    serve(32'h0000_0067, 1, a, wt);
    vec++; if (a !== 32'h200) begin err++; $display("FAIL kill_served_addr got %h exp 00000200", a); end
    vec++; if (inst !== 32'h67) begin err++; $display("FAIL kill_next_inst got %h exp 00000067", inst); end
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_hold();
    logic [31:0] a;
    int wt;
    serve(32'h0000_006F, 1, a, wt);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h302;
    cyc();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    vec++; if (inst_valid !== 1'b0) begin err++; $display("FAIL rh_valid got %b exp 0", inst_valid); end
    vec++; if (imem_req_addr !== 32'h300) begin err++; $display("FAIL rh_addr got %h exp 00000300", imem_req_addr); end
    vec++; if (misalign_err !== 1'b1) begin err++; $display("FAIL rh_misalign got %b exp 1", misalign_err); end
    serve(32'h0000_0013, 2, a, wt);
    vec++; if (inst_pc !== 32'h300) begin err++; $display("FAIL rh_inst_pc got %h exp 00000300", inst_pc); end
    vec++; if (misalign_err !== 1'b1) begin err++; $display("FAIL rh_sticky got %b exp 1", misalign_err); end
    do_reset();
    vec++; if (misalign_err !== 1'b0) begin err++; $display("FAIL rh_cleared got %b exp 0", misalign_err); end
  endtask

  task automatic test_wrap_stall();
    logic [31:0] a;
    int wt;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    vec++; if (imem_req_addr !== 32'hFFFF_FFFC) begin err++; $display("FAIL wrap_addr got %h exp fffffffc", imem_req_addr); end
    serve(32'h0000_0033, 1, a, wt);
    vec++; if (inst_pc !== 32'hFFFF_FFFC) begin err++; $display("FAIL wrap_inst_pc got %h exp fffffffc", inst_pc); end
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      vec++; if (imem_req_valid !== 1'b1) begin err++; $display("FAIL stall_req_valid got %b exp 1", imem_req_valid); end
      vec++; if (imem_req_addr !== 32'h0) begin err++; $display("FAIL stall_addr got %h exp 00000000", imem_req_addr); end
      cyc();
    end
    serve(32'h0000_0037, 1, a, wt);
    vec++; if (inst_pc !== 32'h0) begin err++; $display("FAIL wrap_zero_pc got %h exp 00000000", inst_pc); end
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
  endtask

  // Random traffic checked against a transaction model: next fetch PC,
  // the one outstanding request (and whether it is orphaned), and the
  // instruction currently offered to decode.
  task automatic test_random();
    logic hold, outs, killed, mis, redir, rsp, rdy, ird;
    logic [31:0] pc, hd, hp, oa, tgt;
    int unsigned wt;
    do_reset();
    hold = 0; outs = 0; killed = 0; mis = 0; pc = 32'h100; hd = '0; hp = '0; oa = '0; wt = 0;
    for (int unsigned n = 0; n < 2000; n++) begin
      vec++; if (inst_valid !== hold) begin err++; $display("FAIL rnd_inst_valid n=%0d got %b exp %b", n, inst_valid, hold); end
      if (hold) begin
        vec++; if (inst !== hd) begin err++; $display("FAIL rnd_inst n=%0d got %h exp %h", n, inst, hd); end
        vec++; if (inst_pc !== hp) begin err++; $display("FAIL rnd_inst_pc n=%0d got %h exp %h", n, inst_pc, hp); end
        vec++; if (inst_opcode !== hd[6:0]) begin err++; $display("FAIL rnd_opcode n=%0d got %h exp %h", n, inst_opcode, hd[6:0]); end
      end
      vec++; if (imem_req_valid !== (!hold && !outs)) begin err++; $display("FAIL rnd_req_valid n=%0d got %b exp %b", n, imem_req_valid, !hold && !outs); end
      if (!hold && !outs) begin
        vec++; if (imem_req_addr !== pc) begin err++; $display("FAIL rnd_req_addr n=%0d got %h exp %h", n, imem_req_addr, pc); end
      end
      vec++; if (misalign_err !== mis) begin err++; $display("FAIL rnd_misalign n=%0d got %b exp %b", n, misalign_err, mis); end

      rdy   = ($urandom_range(0, 9) < 6);
      ird   = $urandom_range(0, 1) == 1;
      redir = ($urandom_range(0, 11) == 0);
      tgt   = $urandom;
      if ($urandom_range(0, 1) == 1) tgt[1:0] = 2'b00;
      if (outs) begin
        wt--;
        rsp = (wt == 0);
      end else begin
        rsp = ($urandom_range(0, 7) == 0);
      end
      imem_req_ready = rdy;
      inst_ready     = ird;
      redirect_valid = redir;
      redirect_pc    = tgt;
      imem_rsp_valid = rsp;
      imem_rsp_data  = (outs && rsp) ? memw(oa) : $urandom;

      if (hold) begin
        if (redir) hold = 0;
        else if (ird) begin hold = 0; pc = pc + 32'd4; end
      end else if (outs) begin
        if (rsp) begin
          outs = 0;
          if (!killed && !redir) begin hold = 1; hd = memw(oa); hp = oa; end
          killed = 0;
        end else if (redir) begin
          killed = 1;
        end
      end else if (rdy) begin
        outs = 1; killed = redir; oa = pc; wt = $urandom_range(1, 3);
      end
      if (redir) begin
        pc = {tgt[31:2], 2'b00};
        if (tgt[1:0] != 2'b00) mis = 1;
      end
      cyc();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_kill();
    test_redirect_hold();
    test_wrap_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
